// File: rtl/imhotep_pkg.sv
// Shared execute-stage types and constants for the imhotep RV32I core.
package imhotep_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SHAMT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } op_alu_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA; any other op yields zero.
module alu_shifter
    import imhotep_pkg::*;
(
    input  logic [XLEN-1:0]    a,
    input  logic [SHAMT_W-1:0] amt,
    input  op_alu_e            op,
    output logic [XLEN-1:0]    result
);

    always_comb begin
        result = '0;
        case (op)
            ALU_SLL: result = a << amt;
            ALU_SRL: result = a >> amt;
            ALU_SRA: result = $signed(a) >>> amt;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// imhotep execute-stage integer ALU with registered result and PC+4.
// Optional macro ALU_ZERO_FLAG_EN adds the registered zero_o flag.
module alu
    import imhotep_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic [XLEN-1:0] in1_i,
    input  logic [XLEN-1:0] in2_i,
    input  op_alu_e         op_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [XLEN-1:0] out_o,
    output logic [XLEN-1:0] pc_inc_o
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic            zero_o
`endif
);

    logic [XLEN-1:0] shift_result;
    logic [XLEN-1:0] result;

    // Only the low shift-amount bits of operand B reach the shifter.
    alu_shifter u_shifter (
        .a      (in1_i),
        .amt    (in2_i[SHAMT_W-1:0]),
        .op     (op_i),
        .result (shift_result)
    );

    always_comb begin
        result = '0;
        case (op_i)
            ALU_ADD:   result = in1_i + in2_i;
            ALU_SUB:   result = in1_i - in2_i;
            ALU_AND:   result = in1_i & in2_i;
            ALU_OR:    result = in1_i | in2_i;
            ALU_XOR:   result = in1_i ^ in2_i;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(in1_i) < $signed(in2_i))};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (in1_i < in2_i)};
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:   result = shift_result;
            ALU_PASSB: result = in2_i;
            default:   result = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_o  <= 1'b0;
            out_o    <= '0;
            pc_inc_o <= '0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                out_o    <= result;
                pc_inc_o <= pc_i + PC_STEP;
            end
        end
    end

`ifdef ALU_ZERO_FLAG_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            zero_o <= 1'b0;
        end else if (valid_i) begin
            zero_o <= (result == '0);
        end
    end
`endif

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu (default and ALU_ZERO_FLAG_EN builds).
module tb_alu;
    import imhotep_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid_in;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    op_alu_e         op;
    logic [XLEN-1:0] pc;
    logic            valid_out;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] pc_inc;
`ifdef ALU_ZERO_FLAG_EN
    logic            zero;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    alu dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .valid_i  (valid_in),
        .in1_i    (a),
        .in2_i    (b),
        .op_i     (op),
        .pc_i     (pc),
        .valid_o  (valid_out),
        .out_o    (result),
        .pc_inc_o (pc_inc)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .zero_o   (zero)
`endif
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic vld, input op_alu_e o,
                        input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                        input logic [XLEN-1:0] p);
        @(negedge clk);
        rst_n    = rst;
        valid_in = vld;
        op       = o;
        a        = x;
        b        = y;
        pc       = p;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input string tag, input logic [XLEN-1:0] exp,
                              input logic [XLEN-1:0] exp_pc);
        chk({tag, "_valid"}, XLEN'(valid_out), XLEN'(1));
        chk({tag, "_out"}, result, exp);
        chk({tag, "_pc"}, pc_inc, exp_pc);
`ifdef ALU_ZERO_FLAG_EN
        chk({tag, "_zero"}, XLEN'(zero), XLEN'(exp == '0));
`endif
    endtask

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; op = ALU_ADD; a = '0; b = '0; pc = '0;

        // reset wins over a valid operation
        step(1'b0, 1'b1, ALU_ADD, 32'h1, 32'h4, 32'h100);
        chk("rst_valid", XLEN'(valid_out), XLEN'(0));
        chk("rst_out", result, 32'h0);
        chk("rst_pc", pc_inc, 32'h0);
`ifdef ALU_ZERO_FLAG_EN
        chk("rst_zero", XLEN'(zero), XLEN'(0));
`endif

        step(1'b1, 1'b1, ALU_ADD,  32'h1, 32'h4, 32'h100);
        expect_res("add", 32'h00000005, 32'h00000104);
        step(1'b1, 1'b1, ALU_SUB,  32'h1, 32'h4, 32'h104);
        expect_res("sub", 32'hFFFFFFFD, 32'h00000108);
        step(1'b1, 1'b1, ALU_SUB,  32'h5, 32'h5, 32'h108);
        expect_res("sub_eq", 32'h0, 32'h0000010C);
        step(1'b1, 1'b1, ALU_AND,  32'h0C, 32'h06, 32'h200);
        expect_res("and", 32'h04, 32'h204);
        step(1'b1, 1'b1, ALU_OR,   32'h0C, 32'h06, 32'h204);
        expect_res("or", 32'h0E, 32'h208);
        step(1'b1, 1'b1, ALU_XOR,  32'h0C, 32'h06, 32'h208);
        expect_res("xor", 32'h0A, 32'h20C);
        step(1'b1, 1'b1, ALU_SLT,  32'h0C, 32'h06, 32'h300);
        expect_res("slt_gt", 32'h0, 32'h304);
        step(1'b1, 1'b1, ALU_SLT,  32'h06, 32'h0C, 32'h304);
        expect_res("slt_lt", 32'h1, 32'h308);
        step(1'b1, 1'b1, ALU_SLT,  32'h80000000, 32'h1, 32'h308);
        expect_res("slt_neg", 32'h1, 32'h30C);
        step(1'b1, 1'b1, ALU_SLTU, 32'h80000000, 32'h1, 32'h30C);
        expect_res("sltu_big", 32'h0, 32'h310);
        step(1'b1, 1'b1, ALU_SLTU, 32'h1, 32'h80000000, 32'h310);
        expect_res("sltu_small", 32'h1, 32'h314);
        step(1'b1, 1'b1, ALU_SRL,  32'h80000000, 32'h24, 32'h400);
        expect_res("srl", 32'h08000000, 32'h404);
        step(1'b1, 1'b1, ALU_SRA,  32'h80000000, 32'h24, 32'h404);
        expect_res("sra", 32'hF8000000, 32'h408);
        step(1'b1, 1'b1, ALU_SLL,  32'h80000000, 32'h24, 32'h408);
        expect_res("sll_out", 32'h0, 32'h40C);
        step(1'b1, 1'b1, ALU_SLL,  32'h00000003, 32'hFFFFFFE5, 32'h40C);
        expect_res("sll_amt5", 32'h00000060, 32'h410);
        step(1'b1, 1'b1, ALU_PASSB, 32'hDEADBEEF, 32'h12345000, 32'h500);
        expect_res("passb", 32'h12345000, 32'h504);
        step(1'b1, 1'b1, op_alu_e'(4'hF), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h504);
        expect_res("illegal", 32'h0, 32'h508);

        // PC wrap, then an idle cycle must hold the datapath outputs
        step(1'b1, 1'b1, ALU_ADD,  32'h7, 32'h8, 32'hFFFFFFFC);
        expect_res("pc_wrap", 32'h0000000F, 32'h0);
        step(1'b1, 1'b0, ALU_OR,   32'hAAAA0000, 32'h5555, 32'h1000);
        chk("hold_valid", XLEN'(valid_out), XLEN'(0));
        chk("hold_out", result, 32'h0000000F);
        chk("hold_pc", pc_inc, 32'h0);
`ifdef ALU_ZERO_FLAG_EN
        chk("hold_zero", XLEN'(zero), XLEN'(0));
`endif

        step(1'b1, 1'b1, ALU_XOR,  32'hFF00FF00, 32'h0F0F0F0F, 32'h2000);
        expect_res("resume", 32'hF00FF00F, 32'h2004);
        step(1'b0, 1'b1, ALU_ADD,  32'h1, 32'h1, 32'h3000);
        chk("rst2_valid", XLEN'(valid_out), XLEN'(0));
        chk("rst2_out", result, 32'h0);
        chk("rst2_pc", pc_inc, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
